if_id_fetch_ctrl: RTL and testbench
===================================

IF_ID_FETCH_CTRL -- requirements
Module: if_id_fetch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port pc_in, input, 32 (rv32i_word), current PC from the fetch stage.
REQ-004 SHALL have ports imem_rdata, input, 32 (fetched instruction) and imem_resp, input, 1 (read complete this cycle).
REQ-005 SHALL have port id_stall, input, 1, decode cannot accept a new instruction this cycle.
REQ-006 SHALL have port flush, input, 1, redirect taken; squash all younger fetch state.
REQ-007 SHALL have ports imem_read, output, 1 and imem_address, output, 32, instruction memory request.
REQ-008 SHALL have port load_pc, output, 1, drives the PC register load enable.
REQ-009 SHALL have port if_id_out, output, if_id_reg_t {valid, pc, instr}, the IF/ID register.

Function
REQ-010 SHALL implement states FETCH, HOLD, SQUASH; imem_read=1 in FETCH and SQUASH, 0 in HOLD.
REQ-011 SHALL drive imem_address=pc_in in FETCH and the latched squash_addr in SQUASH.
REQ-012 SHALL drive load_pc = flush | (state==FETCH & imem_resp), combinationally.
REQ-013 FETCH, imem_resp, !id_stall, !flush: if_id_out <= {1, pc_in, imem_rdata} next edge; stay FETCH.
REQ-014 FETCH, imem_resp, id_stall, !flush: capture {pc_in, imem_rdata} into the skid buffer; if_id_out unchanged; go HOLD.
REQ-015 FETCH, !imem_resp, !id_stall, !flush: if_id_out.valid <= 0 (bubble); pc/instr don't-care.
REQ-016 Any state, id_stall & !flush, no capture into if_id_out: if_id_out SHALL hold its value.
REQ-017 HOLD, !id_stall, !flush: if_id_out <= {1, skid pc, skid instr}; go FETCH.
REQ-018 flush SHALL take priority over id_stall and imem_resp: if_id_out <= {0, 0, NOP 0x00000013} next edge; skid invalidated.
REQ-019 flush in FETCH without imem_resp: latch squash_addr=pc_in, go SQUASH; with imem_resp: discard data, stay FETCH.
REQ-020 flush in HOLD: go FETCH; flush in SQUASH: stay SQUASH, squash_addr unchanged.
REQ-021 SQUASH, imem_resp: discard imem_rdata, go FETCH; no response SHALL ever reach if_id_out from SQUASH.
REQ-022 Latency: instruction visible on if_id_out one edge after its imem_resp when ID not stalled.

Reset
REQ-023 On rst: state FETCH; if_id_out={0, 0, 0x00000013}; skid invalid; squash_addr=0; counters 0.
REQ-024 rst SHALL override flush and all other inputs in the same cycle; outputs after reset edge as REQ-010..012 for FETCH.

Configuration
REQ-025 Macro IF_ID_PERF_EN defined: adds outputs stall_cycles (32) counting cycles with imem_read & !imem_resp, and flush_count (32) counting flush cycles; both wrap at 2^32-1 -> 0.
REQ-026 IF_ID_PERF_EN undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-027 if_id_reg_t and constant NOP_INSTR=32'h00000013 SHALL live in package rv32i_types; state enum local to the module.
REQ-028 The skid buffer SHALL be a sub-module if_skid_buf (load, clear, pc/instr storage, valid flag).

Verification
REQ-029 pc_in=0x60, resp with rdata=0x00500093, no stall -> load_pc=1 same cycle; next edge if_id_out={1,0x60,0x00500093}.
REQ-030 resp rdata=0x00A00113 at pc 0x64 with id_stall=1 for 3 cycles -> HOLD, imem_read=0, out unchanged; stall drop -> next edge out={1,0x64,0x00A00113}.
REQ-031 flush while FETCH waiting on address 0x68 -> SQUASH, imem_address stays 0x68 after pc_in changes to 0x100; later resp discarded, then FETCH at 0x100.
REQ-032 flush and id_stall and imem_resp in the same cycle -> out={0,0,0x00000013}, load_pc=1, state FETCH.
REQ-033 rst asserted in HOLD with id_stall=1 -> next edge out={0,0,0x00000013}, state FETCH, imem_read=1.
REQ-034 With IF_ID_PERF_EN: 5 unanswered read cycles and 2 flushes -> stall_cycles=5, flush_count=2.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word, IF/ID pipeline register layout and the canonical NOP.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef struct packed {
    logic      valid;
    rv32i_word pc;
    rv32i_word instr;
  } if_id_reg_t;
  localparam rv32i_word NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding slot for a fetched instruction that decode could not take.
module if_skid_buf
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  rv32i_word pc_d,
  input  rv32i_word instr_d,
  output logic      valid,
  output rv32i_word pc,
  output rv32i_word instr
);
  always_ff @(posedge clk) begin
    if (rst || clear) valid <= 1'b0;
    else if (load) begin
      valid <= 1'b1;
      pc    <= pc_d;
      instr <= instr_d;
    end
  end
endmodule

// File: rtl/if_id_fetch_ctrl.sv
// if_id_fetch_ctrl: fetch handshake and IF/ID register; IF_ID_PERF_EN adds stall/flush counters.
module if_id_fetch_ctrl
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  rv32i_word  pc_in,
  input  rv32i_word  imem_rdata,
  input  logic       imem_resp,
  input  logic       id_stall,
  input  logic       flush,
  output logic       imem_read,
  output rv32i_word  imem_address,
  output logic       load_pc,
  output if_id_reg_t if_id_out
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);
  typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;
  localparam if_id_reg_t IF_ID_RST = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
  state_t     state, state_n;
  rv32i_word  squash_addr, squash_addr_n, skid_pc, skid_instr;
  logic       skid_valid, skid_load;
  if_id_reg_t out_n;
  if_skid_buf u_skid (
    .clk(clk), .rst(rst), .load(skid_load), .clear(flush),
    .pc_d(pc_in), .instr_d(imem_rdata),
    .valid(skid_valid), .pc(skid_pc), .instr(skid_instr)
  );
  assign imem_read    = state != HOLD;
  assign imem_address = state == SQUASH ? squash_addr : pc_in;
  assign load_pc      = flush | (state == FETCH & imem_resp);
  // SQUASH keeps the abandoned request's address stable until its response drains
  always_comb begin
    state_n       = state;
    out_n         = if_id_out;
    squash_addr_n = squash_addr;
    skid_load     = 1'b0;
    if (flush) begin
      out_n         = IF_ID_RST;
      state_n       = (state == FETCH && !imem_resp) || state == SQUASH ? SQUASH : FETCH;
      squash_addr_n = state == FETCH && !imem_resp ? pc_in : squash_addr;
    end else if (state == FETCH) begin
      skid_load = imem_resp & id_stall;
      state_n   = skid_load ? HOLD : FETCH;
      out_n     = id_stall ? if_id_out
                : imem_resp ? '{valid: 1'b1, pc: pc_in, instr: imem_rdata}
                : '{valid: 1'b0, pc: if_id_out.pc, instr: if_id_out.instr};
    end else if (state == HOLD) begin
      out_n   = id_stall ? if_id_out : '{valid: skid_valid, pc: skid_pc, instr: skid_instr};
      state_n = id_stall ? HOLD : FETCH;
    end else begin
      state_n = imem_resp ? FETCH : SQUASH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      if_id_out   <= IF_ID_RST;
      squash_addr <= '0;
    end else begin
      state       <= state_n;
      if_id_out   <= out_n;
      squash_addr <= squash_addr_n;
    end
  end
`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, imem_read & ~imem_resp};
      flush_count  <= flush_count + {31'd0, flush};
    end
  end
`endif
endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// tb_if_id_fetch_ctrl: directed vector table plus reset/squash/counter sequences for if_id_fetch_ctrl.
module tb_if_id_fetch_ctrl;
  import rv32i_types::*;
  localparam logic [31:0] N = 32'h0000_0013;
  typedef struct {
    logic        rst;
    logic [31:0] pc, rd;
    logic        resp, stall, flush;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_load, e_v;
    logic [31:0] e_pc, e_ins;
    logic        addr_dc, data_dc;
  } vec_t;
  logic clk = 1'b0;
  logic rst, imem_resp, id_stall, flush, imem_read, load_pc;
  rv32i_word pc_in, imem_rdata, imem_address;
  if_id_reg_t if_id_out;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[23];
  if_id_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .id_stall(id_stall), .flush(flush),
    .imem_read(imem_read), .imem_address(imem_address), .load_pc(load_pc),
    .if_id_out(if_id_out)
`ifdef IF_ID_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] d,
                       input logic rs, input logic st, input logic fl);
    rst = r; pc_in = p; imem_rdata = d; imem_resp = rs; id_stall = st; flush = fl;
  endtask
  task automatic chk_out_full(input string tag, input logic v, input logic [31:0] p, input logic [31:0] ins);
    chk({tag, ".valid"}, {31'd0, if_id_out.valid}, {31'd0, v});
    chk({tag, ".pc"}, if_id_out.pc, p);
    chk({tag, ".instr"}, if_id_out.instr, ins);
  endtask
  initial begin
    //         rst pc           rd           rsp stl fl  rd  addr         ld  v   pc           ins          adc ddc
    tbl[0]  = '{0, 32'h60,      32'h00500093, 1, 0, 0,  1, 32'h60,      1,  1, 32'h60,      32'h00500093, 0, 0};
    tbl[1]  = '{0, 32'h64,      32'h0,        0, 0, 0,  1, 32'h64,      0,  0, 32'h0,       32'h0,        0, 1};
    tbl[2]  = '{0, 32'h64,      32'h00A00113, 1, 1, 0,  1, 32'h64,      1,  0, 32'h0,       32'h0,        0, 1};
    tbl[3]  = '{0, 32'h68,      32'h0,        0, 1, 0,  0, 32'h0,       0,  0, 32'h0,       32'h0,        1, 1};
    tbl[4]  = '{0, 32'h68,      32'h0,        0, 1, 0,  0, 32'h0,       0,  0, 32'h0,       32'h0,        1, 1};
    tbl[5]  = '{0, 32'h68,      32'h0,        0, 0, 0,  0, 32'h0,       0,  1, 32'h64,      32'h00A00113, 1, 0};
    tbl[6]  = '{0, 32'h68,      32'h0,        0, 0, 1,  1, 32'h68,      1,  0, 32'h0,       N,            0, 0};
    tbl[7]  = '{0, 32'h100,     32'h0,        0, 0, 0,  1, 32'h68,      0,  0, 32'h0,       N,            0, 0};
    tbl[8]  = '{0, 32'h100,     32'hDEADBEEF, 1, 0, 0,  1, 32'h68,      0,  0, 32'h0,       N,            0, 0};
    tbl[9]  = '{0, 32'h100,     32'h00000033, 1, 0, 0,  1, 32'h100,     1,  1, 32'h100,     32'h00000033, 0, 0};
    tbl[10] = '{0, 32'h104,     32'h11111111, 1, 1, 1,  1, 32'h104,     1,  0, 32'h0,       N,            0, 0};
    tbl[11] = '{0, 32'h200,     32'h22222222, 1, 0, 0,  1, 32'h200,     1,  1, 32'h200,     32'h22222222, 0, 0};
    tbl[12] = '{0, 32'h204,     32'h33333333, 1, 1, 0,  1, 32'h204,     1,  1, 32'h200,     32'h22222222, 0, 0};
    tbl[13] = '{0, 32'h208,     32'h0,        0, 1, 1,  0, 32'h0,       1,  0, 32'h0,       N,            1, 0};
    tbl[14] = '{0, 32'h300,     32'h0,        0, 1, 0,  1, 32'h300,     0,  0, 32'h0,       N,            0, 0};
    tbl[15] = '{0, 32'h300,     32'h00000044, 1, 1, 0,  1, 32'h300,     1,  0, 32'h0,       N,            0, 0};
    tbl[16] = '{1, 32'h304,     32'h0,        0, 1, 0,  0, 32'h0,       0,  0, 32'h0,       N,            1, 0};
    tbl[17] = '{0, 32'h400,     32'h0,        0, 0, 0,  1, 32'h400,     0,  0, 32'h0,       32'h0,        0, 1};
    tbl[18] = '{0, 32'h500,     32'h0,        0, 0, 1,  1, 32'h500,     1,  0, 32'h0,       N,            0, 0};
    tbl[19] = '{0, 32'h600,     32'h0,        0, 0, 1,  1, 32'h500,     1,  0, 32'h0,       N,            0, 0};
    tbl[20] = '{0, 32'h600,     32'h0,        0, 0, 0,  1, 32'h500,     0,  0, 32'h0,       N,            0, 0};
    tbl[21] = '{0, 32'h600,     32'h00000055, 1, 0, 0,  1, 32'h500,     0,  0, 32'h0,       N,            0, 0};
    tbl[22] = '{0, 32'h600,     32'h00000066, 1, 0, 0,  1, 32'h600,     1,  1, 32'h600,     32'h00000066, 0, 0};
    drive(1, 32'h40, 32'hFFFFFFFF, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1 chk_out_full("reset", 1'b0, 32'h0, N);
    @(negedge clk);
    drive(0, 32'h40, 32'h0, 0, 0, 0);
    #1;
    chk("reset.imem_read", {31'd0, imem_read}, 32'd1);
    chk("reset.imem_address", imem_address, 32'h40);
    chk("reset.load_pc", {31'd0, load_pc}, 32'd0);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].pc, tbl[i].rd, tbl[i].resp, tbl[i].stall, tbl[i].flush);
      #1;
      chk($sformatf("v%0d.imem_read", i), {31'd0, imem_read}, {31'd0, tbl[i].e_read});
      if (!tbl[i].addr_dc) chk($sformatf("v%0d.imem_address", i), imem_address, tbl[i].e_addr);
      chk($sformatf("v%0d.load_pc", i), {31'd0, load_pc}, {31'd0, tbl[i].e_load});
      @(posedge clk);
      #1;
      if (tbl[i].data_dc) chk($sformatf("v%0d.valid", i), {31'd0, if_id_out.valid}, {31'd0, tbl[i].e_v});
      else chk_out_full($sformatf("v%0d", i), tbl[i].e_v, tbl[i].e_pc, tbl[i].e_ins);
    end
    // reset with flush asserted, then five unanswered reads containing two flushes
    @(negedge clk);
    drive(1, 32'h700, 32'h0, 0, 1, 1);
    @(negedge clk);
    drive(0, 32'h700, 32'h0, 0, 0, 1);
    #1 chk("seq.imem_address0", imem_address, 32'h700);
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      drive(0, 32'h800, 32'h0, 0, 0, c == 2);
      #1 chk($sformatf("seq.imem_address%0d", c), imem_address, 32'h700);
    end
    @(negedge clk);
    drive(0, 32'h800, 32'h0, 0, 0, 0);
    #1;
    chk("seq.imem_read", {31'd0, imem_read}, 32'd1);
    chk_out_full("seq", 1'b0, 32'h0, N);
`ifdef IF_ID_PERF_EN
    chk("seq.stall_cycles", stall_cycles, 32'd5);
    chk("seq.flush_count", flush_count, 32'd2);
`endif
    drive(0, 32'h800, 32'hAAAAAAAA, 1, 0, 0);
    @(posedge clk);
    #1 chk("seq.squash_drop.valid", {31'd0, if_id_out.valid}, 32'd0);
    chk("seq.fetch.imem_address", imem_address, 32'h800);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
